// File: rtl/pll_ctrl_pkg.sv
// PLL bring-up sequencer shared types and constants.
// Imported by the sequencer top level.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG,
        ST_CP_ON,
        ST_VCO_SETTLE,
        ST_MEASURE,
        ST_LOCKED,
        ST_FAULT
    } pll_state_t;

    localparam int PROG_LEN = 8;
    localparam int FB_DIV   = 64;
    localparam int CNT_W    = 8;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_fb_sync.sv
// Feedback clock synchroniser with rising-edge detect.
// Emits a single REF_CLK-cycle pulse per FB_CLK rising edge.
module pll_fb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic fb_clk,
    output logic fb_pulse
);

    // [0],[1] synchronise; [2] is the delayed copy for edge detect
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], fb_clk};
        end
    end

    assign fb_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pll_ctrl_seq.sv
// PLL bring-up sequencer: program divider, enable charge pump and VCO,
// then verify the feedback frequency over repeated measurement windows.
module pll_ctrl_seq
    import pll_ctrl_pkg::*;
#(
    parameter int CP_DLY  = 64,
    parameter int VCO_DLY = 1024,
    parameter int WIN     = 256,
    parameter int TOL     = 1,
    parameter int MAX_TRY = 3
) (
    input  logic       REF_CLK,
    input  logic       PORB,
    input  logic       START,
    input  logic       STOP,
    input  logic [3:0] MULT,
    input  logic       FB_CLK,
    output logic [3:0] B_pll,
    output logic       EN_CP_pll,
    output logic       EN_VCO_pll,
    output logic       LOCK,
    output logic       FAULT,
    output logic       BUSY
);

    localparam int T_A   = (CP_DLY > VCO_DLY) ? CP_DLY : VCO_DLY;
    localparam int T_B   = (T_A > WIN) ? T_A : WIN;
    localparam int T_MX  = (T_B > PROG_LEN) ? T_B : PROG_LEN;
    localparam int TW    = $clog2(T_MX + 1);
    localparam int TRY_W = $clog2(MAX_TRY + 1);
    localparam int EXP_PER_MULT = WIN / FB_DIV;

    localparam logic [TW-1:0] PROG_END = TW'(PROG_LEN - 1);
    localparam logic [TW-1:0] ZERO_END = TW'(PROG_LEN);
    localparam logic [TW-1:0] CP_END   = TW'(CP_DLY - 1);
    localparam logic [TW-1:0] VCO_END  = TW'(VCO_DLY - 1);
    localparam logic [TW-1:0] WIN_END  = TW'(WIN - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY - 1);

    pll_state_t       state_q, state_d;
    logic [3:0]       b_q, b_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] edge_q, edge_d, edge_now;
    logic [TRY_W-1:0] try_q, try_d;
    logic             pass_q, pass_d;
    logic             fb_pulse;
    logic             measuring;
    logic             win_end;
    logic             win_pass;
    int               exp_cnt;
    int               diff;

    pll_fb_sync u_fb_sync (
        .clk      (REF_CLK),
        .rst_n    (PORB),
        .fb_clk   (FB_CLK),
        .fb_pulse (fb_pulse)
    );

    assign measuring = (state_q == ST_MEASURE) ||
                       (state_q == ST_LOCKED);
    assign win_end   = measuring && (timer_q == WIN_END);
    // Edge on the closing cycle still belongs to this window
    assign edge_now  = fb_pulse ? sat_inc(edge_q) : edge_q;

    always_comb begin
        exp_cnt  = int'(b_q) * EXP_PER_MULT;
        diff     = int'(edge_now) - exp_cnt;
        win_pass = (diff <= TOL) && (diff >= -TOL);
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        try_d   = try_q;
        pass_d  = pass_q;
        timer_d = timer_q + 1'b1;
        edge_d  = '0;
        unique case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (START) begin
                    state_d = ST_PROG;
                    b_d     = MULT;
                end
            end
            ST_PROG: begin
                // Zero divider is rejected one cycle after PROG ends
                if (b_q == 4'd0) begin
                    if (timer_q == ZERO_END) state_d = ST_FAULT;
                end else if (timer_q == PROG_END) begin
                    state_d = ST_CP_ON;
                end
            end
            ST_CP_ON: begin
                if (timer_q == CP_END) state_d = ST_VCO_SETTLE;
            end
            ST_VCO_SETTLE: begin
                if (timer_q == VCO_END) begin
                    state_d = ST_MEASURE;
                    try_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (win_end) begin
                    if (win_pass) begin
                        if (pass_q) begin
                            state_d = ST_LOCKED;
                            pass_d  = 1'b0;
                        end else begin
                            pass_d  = 1'b1;
                        end
                    end else begin
                        pass_d = 1'b0;
                        if (try_q == TRY_LAST) state_d = ST_FAULT;
                        else try_d = try_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (win_end && !win_pass) begin
                    state_d = ST_MEASURE;
                    try_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (STOP) begin
            state_d = ST_IDLE;
            b_d     = b_q;
        end

        if ((state_d != state_q) || win_end ||
            (state_d == ST_IDLE) || (state_d == ST_FAULT)) begin
            timer_d = '0;
        end

        if (measuring && !win_end && (state_d == state_q)) begin
            edge_d = edge_now;
        end
    end

    always_ff @(posedge REF_CLK or negedge PORB) begin
        if (!PORB) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            timer_q <= '0;
            edge_q  <= '0;
            try_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            timer_q <= timer_d;
            edge_q  <= edge_d;
            try_q   <= try_d;
            pass_q  <= pass_d;
        end
    end

    assign B_pll      = b_q;
    assign EN_CP_pll  = (state_q == ST_CP_ON) ||
                        (state_q == ST_VCO_SETTLE) || measuring;
    assign EN_VCO_pll = (state_q == ST_VCO_SETTLE) || measuring;
    assign LOCK       = (state_q == ST_LOCKED);
    assign FAULT      = (state_q == ST_FAULT);
    assign BUSY       = !((state_q == ST_IDLE) ||
                          (state_q == ST_LOCKED) ||
                          (state_q == ST_FAULT));

endmodule

// File: doc/pll_ctrl_seq.md
PLL_CTRL_SEQ -- requirements
Module: pll_ctrl_seq

Interface
REQ-001 Parameter CP_DLY, default 64: REF_CLK cycles EN_CP is held before EN_VCO asserts.
REQ-002 Parameter VCO_DLY, default 1024: REF_CLK cycles of VCO settle before the first measurement.
REQ-003 Parameter WIN, default 256: measurement window length in REF_CLK cycles; power of two, at least 64.
REQ-004 Parameter TOL, default 1: allowed ± deviation of the feedback edge count.
REQ-005 Parameter MAX_TRY, default 3: failed windows tolerated before FAULT.
REQ-006 REF_CLK  in  1  sole clock; all logic rising-edge.
REQ-007 PORB  in  1  reset, asynchronous, active-low.
REQ-008 START  in  1  single-cycle request to begin bring-up.
REQ-009 STOP  in  1  single-cycle request to shut the PLL down.
REQ-010 MULT  in  4  requested multiplication factor, 1..15.
REQ-011 FB_CLK  in  1  PLL output pre-divided by 64, asynchronous to REF_CLK.
REQ-012 B_pll  out  4  divider control bits to the PLL.
REQ-013 EN_CP_pll  out  1  charge-pump enable.
REQ-014 EN_VCO_pll  out  1  VCO enable.
REQ-015 LOCK  out  1  frequency verified.
REQ-016 FAULT  out  1  bring-up failed or illegal MULT.
REQ-017 BUSY  out  1  high in every state except IDLE, LOCKED and FAULT.

Function
REQ-018 States SHALL be IDLE, PROG, CP_ON, VCO_SETTLE, MEASURE, LOCKED and FAULT.
REQ-019 START in IDLE or FAULT SHALL latch MULT into B_pll, clear FAULT, and enter PROG; START is ignored in all other states.
REQ-020 A latched MULT of 0 SHALL go from PROG directly to FAULT on the next cycle, with both enables kept low.
REQ-021 PROG SHALL last 8 cycles with B_pll stable, then enter CP_ON.
REQ-022 EN_CP_pll SHALL assert on entry to CP_ON; after CP_DLY cycles, EN_VCO_pll SHALL assert and the state SHALL become VCO_SETTLE.
REQ-023 After VCO_DLY cycles, VCO_SETTLE SHALL enter MEASURE with the try count cleared.
REQ-024 FB_CLK SHALL pass a 2-flop synchroniser and a rising-edge detector; each detected edge increments an 8-bit saturating counter during a window.
REQ-025 At window end, the expected count is MULT*WIN/64 and the window passes if |count − expected| ≤ TOL; the counter clears and the next window starts on the following cycle.
REQ-026 In MEASURE, two consecutive passes SHALL enter LOCKED and assert LOCK; a fail clears the pass streak and increments the try count.
REQ-027 When the try count reaches MAX_TRY, the block SHALL enter FAULT, assert FAULT, and drop both enables in the same cycle.
REQ-028 LOCKED SHALL keep measuring; one failed window SHALL deassert LOCK and return to MEASURE with the try count cleared.
REQ-029 STOP in any state SHALL enter IDLE next cycle with both enables low, LOCK and FAULT low, and B_pll held; STOP wins over a simultaneous START.
REQ-030 B_pll SHALL change only on an accepted START.

Reset
REQ-031 With PORB low: state IDLE, B_pll=0, EN_CP_pll=0, EN_VCO_pll=0, LOCK=0, FAULT=0, BUSY=0, all counters and synchroniser flops 0.
REQ-032 PORB assertion mid-sequence SHALL take effect immediately; after release, the block waits for a new START.

Structure
REQ-033 Package pll_ctrl_pkg SHALL hold the state enum, PROG length 8, the feedback pre-divide of 64, and the counter width 8.
REQ-034 Sub-module pll_fb_sync SHALL contain the synchroniser and edge detector, with a single-cycle pulse output.

Verification
REQ-035 MULT=8, FB_CLK period of 8 REF_CLK cycles: B_pll=8 after START; EN_CP_pll at +8; EN_VCO_pll at +72; LOCK after 2 windows of 32 edges each.
REQ-036 MULT=8, FB_CLK giving 30 edges per window: three fails, then FAULT=1 and both enables 0; LOCK never asserts.
REQ-037 MULT=0 with START: FAULT=1 at 9 cycles after START; EN_CP_pll never asserts.
REQ-038 Lock achieved at MULT=4 (16 edges), then FB_CLK stops: LOCK=0 after the next window end, state MEASURE; restoring FB_CLK relocks after 2 windows.
REQ-039 START and STOP in the same cycle during VCO_SETTLE: IDLE next cycle with enables low; a later START from IDLE succeeds.
REQ-040 PORB pulsed low during MEASURE: all outputs go to reset values asynchronously and stay there until START.
